reorder_buff_param: RTL

Parametrised reorder buffer for the Tomasulo core: a circular queue of `DEPTH` entries with head/tail pointers, `NUM_CDB` simultaneous common-data-bus writeback channels and strict in-order commit under a ready/valid handshake. It sits between the instruction handler, which allocates entries at dispatch; the CDB, which supplies results by ROB tag; and the register file / renaming table, which consumes commits. A single-cycle flush supports misprediction recovery.

---
 rtl/rob_pkg.sv | 18 +
 rtl/rob_entry.sv | 47 ++++
 rtl/reorder_buff_param.sv | 94 +++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: shared defaults, entry record and pointer increment for the reorder buffer
package rob_pkg;
  localparam int ROB_DEPTH   = 8;
  localparam int ROB_NUM_CDB = 6;
  localparam int ROB_DATA_W  = 32;
  localparam int ROB_DEST_W  = 5;
  localparam int ROB_RS_W    = 4;
  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic [ROB_DEST_W-1:0] dest;
    logic [ROB_RS_W-1:0]   rs;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;
  function automatic logic [31:0] rob_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr + 32'd1) % depth;
  endfunction
endpackage

// File: rtl/rob_entry.sv
// rob_entry: one reorder-buffer slot holding busy/done flags, dest, rs and result
//   set/set_dest/set_rs: allocate; clear: commit; flush: discard
//   wb_sel/wb_data: CDB write, taken only while busy and not yet done
module rob_entry #(
  parameter int DEST_W = 5,
  parameter int RS_W   = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              set,
  input  logic              clear,
  input  logic              wb_sel,
  input  logic [DEST_W-1:0] set_dest,
  input  logic [RS_W-1:0]   set_rs,
  input  logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              done,
  output logic [DEST_W-1:0] dest,
  output logic [RS_W-1:0]   rs,
  output logic [DATA_W-1:0] data
);
  logic wb_take;
  assign wb_take = wb_sel && busy && !done;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (set) begin
      busy <= 1'b1;
      done <= 1'b0;
    end else if (clear) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (wb_take) begin
      done <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (set) begin
      dest <= set_dest;
      rs   <= set_rs;
    end
    if (wb_take) data <= wb_data;
  end
endmodule

// File: rtl/reorder_buff_param.sv
// reorder_buff_param: circular reorder buffer with multi-channel CDB writeback and in-order commit
//   alloc_*: dispatch handshake, alloc_tag = tail; cdb_*: per-channel result by tag
//   commit_*: head entry handshake; flush: discard all; busy/count: occupancy
module reorder_buff_param
  import rob_pkg::*;
#(
  parameter int DEPTH   = ROB_DEPTH,
  parameter int NUM_CDB = ROB_NUM_CDB,
  parameter int DATA_W  = ROB_DATA_W,
  parameter int DEST_W  = ROB_DEST_W,
  parameter int RS_W    = ROB_RS_W,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  input  logic [DEST_W-1:0]         alloc_dest,
  input  logic [RS_W-1:0]           alloc_rs,
  output logic [IDX_W-1:0]          alloc_tag,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*IDX_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic                      commit_valid,
  input  logic                      commit_ready,
  output logic [DEST_W-1:0]         commit_dest,
  output logic [DATA_W-1:0]         commit_data,
  output logic [RS_W-1:0]           commit_rs,
  output logic [IDX_W-1:0]          commit_tag,
  input  logic                      flush,
  output logic [DEPTH-1:0]          busy,
  output logic [IDX_W:0]            count
);
  logic [IDX_W-1:0]  head, tail;
  logic              alloc_fire, commit_fire;
  logic [DEPTH-1:0]  done_v, set_v, clr_v, wb_sel;
  logic [DATA_W-1:0] wb_data [DEPTH];
  logic [DEST_W-1:0] dest_v  [DEPTH];
  logic [RS_W-1:0]   rs_v    [DEPTH];
  logic [DATA_W-1:0] data_v  [DEPTH];
  assign alloc_ready  = count < (IDX_W+1)'(DEPTH);
  assign alloc_fire   = alloc_valid && alloc_ready;
  assign commit_valid = busy[head] && done_v[head];
  assign commit_fire  = commit_valid && commit_ready;
  assign set_v        = alloc_fire ? DEPTH'(1) << tail : '0;
  assign clr_v        = commit_fire ? DEPTH'(1) << head : '0;
  assign alloc_tag    = tail;
  assign commit_tag   = head;
  assign commit_dest  = dest_v[head];
  assign commit_data  = data_v[head];
  assign commit_rs    = rs_v[head];
  // Channels are scanned high to low so the lowest matching channel is the last writer.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wb_sel[i]  = 1'b0;
      wb_data[i] = '0;
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (cdb_valid[k] && cdb_tag[k*IDX_W +: IDX_W] == IDX_W'(i)) begin
          wb_sel[i]  = 1'b1;
          wb_data[i] = cdb_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire) tail <= IDX_W'(rob_inc(32'(tail), 32'(DEPTH)));
      if (commit_fire) head <= IDX_W'(rob_inc(32'(head), 32'(DEPTH)));
      count <= count + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
    end
  end
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    rob_entry #(.DEST_W(DEST_W), .RS_W(RS_W), .DATA_W(DATA_W)) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .set      (set_v[e]),
      .clear    (clr_v[e]),
      .wb_sel   (wb_sel[e]),
      .set_dest (alloc_dest),
      .set_rs   (alloc_rs),
      .wb_data  (wb_data[e]),
      .busy     (busy[e]),
      .done     (done_v[e]),
      .dest     (dest_v[e]),
      .rs       (rs_v[e]),
      .data     (data_v[e])
    );
  end
endmodule
